// File: rtl/inst_fetch_mem.sv
// Instruction-memory responder for the fetch front end.
// Returns FETCH_W consecutive words per request after LATENCY cycles, using a
// Read/Ready handshake, and takes preload writes through the load_* port.
// Optional build macro: INST_FETCH_ALIGN_EN. When defined, a fetch group is
// clipped at the FETCH_W-aligned boundary and never wraps past the top of memory.
module inst_fetch_mem #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned FETCH_W    = 2,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      InstMem_Read,
  input  logic [31:0]               inst_address,
  output logic                      InstMem_Ready,
  output logic [FETCH_W*DATA_W-1:0] inst_out,
  output logic [FETCH_W-1:0]        inst_valid,
  input  logic                      load_en,
  input  logic [DEPTH_LOG2-1:0]     load_addr,
  input  logic [DATA_W-1:0]         load_data,
  output logic                      busy
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [DATA_W-1:0]         r_mem [Depth];
  state_e                    r_state;
  logic [2:0]                r_cnt;
  logic                      r_ready;
  logic                      r_busy;
  logic [FETCH_W*DATA_W-1:0] r_data;
  logic [FETCH_W-1:0]        r_valid;

  logic [DEPTH_LOG2-1:0]     w_idx;
  logic [DEPTH_LOG2-1:0]     w_slot_idx;
  logic [FETCH_W*DATA_W-1:0] w_fetch_data;
  logic [FETCH_W-1:0]        w_fetch_valid;
  logic                      w_accept;
  logic                      w_unused;

  assign w_idx    = inst_address[DEPTH_LOG2+1:2];
  // Byte-offset bits and aliased upper bits carry no information here.
  assign w_unused = ^{inst_address[31:DEPTH_LOG2+2], inst_address[1:0]};
  assign w_accept = InstMem_Read && ((r_state == StIdle) || (r_state == StResp));

`ifdef INST_FETCH_ALIGN_EN
  logic [31:0] w_grp_off;
  assign w_grp_off = 32'(w_idx) % FETCH_W;
`endif

  // Preload port: not reset, so the image survives a core reset.
  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  // Gather the fetch group starting at the requested word.
  always_comb begin
    w_fetch_data  = '0;
    w_fetch_valid = '0;
    w_slot_idx    = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      w_slot_idx = w_idx + DEPTH_LOG2'(k);
`ifdef INST_FETCH_ALIGN_EN
      if ((w_grp_off + 32'(k) < FETCH_W) && (32'(w_idx) + 32'(k) < Depth)) begin
        w_fetch_data[k*DATA_W +: DATA_W] = r_mem[w_slot_idx];
        w_fetch_valid[k]                 = 1'b1;
      end
`else
      w_fetch_data[k*DATA_W +: DATA_W] = r_mem[w_slot_idx];
      w_fetch_valid[k]                 = 1'b1;
`endif
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
      r_valid <= '0;
    end else if (w_accept) begin
      // Nonblocking read of r_mem: a same-edge preload write is not seen.
      r_data  <= w_fetch_data;
      r_valid <= w_fetch_valid;
      r_cnt   <= 3'(LATENCY - 1);
      r_busy  <= 1'b1;
      if (LATENCY == 1) begin
        r_state <= StResp;
        r_ready <= 1'b1;
      end else begin
        r_state <= StWait;
        r_ready <= 1'b0;
      end
    end else begin
      case (r_state)
        StWait: begin
          if (r_cnt == 3'd1) begin
            r_state <= StResp;
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign InstMem_Ready = r_ready;
  assign inst_out      = r_data;
  assign inst_valid    = r_valid;
  assign busy          = r_busy;

endmodule
